// File: rtl/blink_monitor.sv
// Blink line checker: synchronizes an async toggle line, measures toggle intervals and flags a stuck line.
// Edge is seen two clocks after sampling; all outputs registered one clock later. No backpressure.
module blink_monitor #(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned HALF_PERIOD = CLK_FREQ / 10,
  parameter int unsigned TOLERANCE   = HALF_PERIOD / 8,
  parameter int unsigned TIMEOUT     = 4 * HALF_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blink_in,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        in_range,
  output logic        stuck,
  output logic [15:0] toggles
);

  localparam logic [31:0] TIMEOUT_W = TIMEOUT;
  localparam logic [31:0] RANGE_LO  = HALF_PERIOD - TOLERANCE;
  localparam logic [31:0] RANGE_HI  = HALF_PERIOD + TOLERANCE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } state_t;

  state_t      state, state_n;
  logic        s1, s2, prev;
  logic        edge_det;
  logic        at_timeout;
  logic [31:0] cnt;

  logic [31:0] period_n;
  logic        period_valid_n;
  logic        in_range_n;
  logic        stuck_n;
  logic [15:0] toggles_n;

  // s1/s2 form the synchronizer; prev holds the last synchronized level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= blink_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign edge_det   = s2 ^ prev;
  assign at_timeout = (cnt == TIMEOUT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= 32'd1;
    end else if (!at_timeout) begin
      cnt <= cnt + 32'd1;
    end
  end

  always_comb begin
    state_n        = state;
    period_n       = period;
    period_valid_n = 1'b0;
    in_range_n     = in_range;
    stuck_n        = stuck;
    toggles_n      = toggles;

    if (edge_det) begin
      toggles_n = toggles + 16'd1;
    end

    // an edge coinciding with the timeout takes priority over declaring stuck
    unique case (state)
      IDLE: begin
        if (edge_det) begin
          state_n = MEAS;
        end else if (at_timeout) begin
          state_n    = STUCK;
          stuck_n    = 1'b1;
          in_range_n = 1'b0;
        end
      end
      MEAS: begin
        if (edge_det) begin
          period_n       = cnt;
          period_valid_n = 1'b1;
          in_range_n     = (cnt >= RANGE_LO) && (cnt <= RANGE_HI);
        end else if (at_timeout) begin
          state_n    = STUCK;
          stuck_n    = 1'b1;
          in_range_n = 1'b0;
        end
      end
      STUCK: begin
        // recovering edge only re-arms: its interval is unknown
        if (edge_det) begin
          state_n = MEAS;
          stuck_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      stuck        <= 1'b0;
      toggles      <= '0;
    end else begin
      state        <= state_n;
      period       <= period_n;
      period_valid <= period_valid_n;
      in_range     <= in_range_n;
      stuck        <= stuck_n;
      toggles      <= toggles_n;
    end
  end

endmodule
